// File: rtl/sec_pkg.sv
// sec_pkg: shared types and limits for the countdown seconds block.
// Holds the FSM state enum, BCD digit type and saturation helper.
package sec_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } sec_down_state_t;

   localparam bcd_t SEC_H_MAX = 4'd5;
   localparam bcd_t SEC_L_MAX = 4'd9;

   function automatic bcd_t bcd_sat(bcd_t d, bcd_t max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/sec_down_if.sv
// sec_down_if: control and display bundle of the countdown block.
// master drives load/control, slave is the counter.
interface sec_down_if;
   import sec_pkg::*;

   logic clear;
   logic start_stop;
   logic load;
   bcd_t load_h;
   bcd_t load_l;
   bcd_t sec_h;
   bcd_t sec_l;
   logic running;
   logic done;

   modport master (
      output clear, start_stop, load, load_h, load_l,
      input  sec_h, sec_l, running, done
   );

   modport slave (
      input  clear, start_stop, load, load_h, load_l,
      output sec_h, sec_l, running, done
   );

endinterface

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: prescaler producing one tick every TICK_DIV enabled
// cycles; holds its count while disabled, sync_clr returns it to 0.
module sec_tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int unsigned CW =
      (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = en && (cnt_q == LAST);

   // next count: clear, wrap at LAST, or hold when disabled
   always_comb begin
      cnt_d = cnt_q;
      if (sync_clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // prescaler count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sec_down.sv
// sec_down: BCD 00-59 countdown with load/clear/start_stop control.
// Define SEC_DOWN_AUTO_RELOAD_EN to reload from the last load at 00.
module sec_down #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   sec_down_if.slave  bus
);
   import sec_pkg::*;

   sec_down_state_t state_q;
   bcd_t            sec_h_q;
   bcd_t            sec_l_q;
   logic            running_q;
   logic            done_q;

   bcd_t ld_h_d;
   bcd_t ld_l_d;
   bcd_t dec_h_d;
   bcd_t dec_l_d;
   logic last_d;
   logic tick;
   logic reload_ok;

   assign ld_h_d = bcd_sat(bus.load_h, SEC_H_MAX);
   assign ld_l_d = bcd_sat(bus.load_l, SEC_L_MAX);
   assign last_d = (sec_h_q == 4'd0) && (sec_l_q == 4'd1);

   // one-second decrement with tens borrow, pinned at 00
   always_comb begin
      dec_h_d = sec_h_q;
      dec_l_d = sec_l_q;
      if (sec_l_q != 4'd0) begin
         dec_l_d = sec_l_q - 4'd1;
      end else if (sec_h_q != 4'd0) begin
         dec_l_d = SEC_L_MAX;
         dec_h_d = sec_h_q - 4'd1;
      end
   end

   sec_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (state_q == ST_RUN),
      .sync_clr (bus.clear | bus.load),
      .tick     (tick)
   );

`ifdef SEC_DOWN_AUTO_RELOAD_EN
   bcd_t rel_h_q;
   bcd_t rel_l_q;

   // reload value captured on every accepted load, kept by clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_h_q <= '0;
         rel_l_q <= '0;
      end else if (!bus.clear && bus.load) begin
         rel_h_q <= ld_h_d;
         rel_l_q <= ld_l_d;
      end
   end

   assign reload_ok = (rel_h_q != '0) || (rel_l_q != '0);
`else
   assign reload_ok = 1'b0;
`endif

   // control FSM with registered digits, running and done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sec_h_q   <= '0;
         sec_l_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else if (bus.clear) begin
         state_q   <= ST_IDLE;
         sec_h_q   <= '0;
         sec_l_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else if (bus.load) begin
         state_q   <= ST_IDLE;
         sec_h_q   <= ld_h_d;
         sec_l_q   <= ld_l_d;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (state_q == ST_DONE);
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start_stop &&
                   (sec_h_q != '0 || sec_l_q != '0)) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.start_stop) begin
                  state_q   <= ST_PAUSE;
                  running_q <= 1'b0;
               end
               if (tick) begin
                  sec_h_q <= dec_h_d;
                  sec_l_q <= dec_l_d;
                  if (last_d) begin
                     done_q <= 1'b1;
                     if (!reload_ok) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                     end
`ifdef SEC_DOWN_AUTO_RELOAD_EN
                     else begin
                        sec_h_q <= rel_h_q;
                        sec_l_q <= rel_l_q;
                     end
`endif
                  end
               end
            end
            ST_PAUSE: begin
               if (bus.start_stop) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_DONE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.sec_h   = sec_h_q;
   assign bus.sec_l   = sec_l_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;

endmodule
